// File: rtl/digit_scan_driver.sv
// digit_scan_driver
//
// Time-multiplexed scan driver for the three-digit seven-segment time display.
// It produces the digit select for the external 3-to-1 mux and decodes the
// muxed digit that comes back into active-low segments. It also drives the
// active-low anodes, with a guard interval at the start of every digit slot
// so that a digit is never lit while the segments still show the previous
// digit.
//
// Parameters:
//   REFRESH_DIV   clock cycles per digit slot (4 .. 2^20)
//   GUARD_CYCLES  cycles at the start of each slot with all anodes off
//                 (2 .. REFRESH_DIV-1)
//
// Ports:
//   clk         system clock, single domain
//   reset       synchronous, active-high reset
//   selector    [1:0] digit select to the external mux: 2 = C (MSD), 1 = B, 0 = A
//   digit_in    [3:0] muxed digit value for the current selector
//   blank       forces all anodes off while high; scanning keeps running
//   an          [3:0] active-low anode enables; an[2:0] follow selector 2..0,
//               an[3] is always off
//   seg         [6:0] active-low segments {g,f,e,d,c,b,a}, registered hex decode
//   dp          active-low decimal point, always off
//   frame_done  one-cycle pulse when a full 2 -> 1 -> 0 scan completes
//
// Optional feature, selected by the macro LEADING_ZERO_BLANK_EN:
//   leading-zero suppression. Digit C stays dark when it is zero, and digit B
//   stays dark when it is zero and digit C was zero in this frame. Digit A
//   is always shown.

module digit_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] selector,
  input  logic [3:0] digit_in,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       selector_q, selector_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_done_q, frame_done_d;
  logic             tick;
  logic             digit_on;
`ifdef LEADING_ZERO_BLANK_EN
  logic             lz_q, lz_d;
`endif

  // Standard hex glyphs, active-low, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] glyph;
    case (value)
      4'h0:    glyph = 7'b1000000;
      4'h1:    glyph = 7'b1111001;
      4'h2:    glyph = 7'b0100100;
      4'h3:    glyph = 7'b0110000;
      4'h4:    glyph = 7'b0011001;
      4'h5:    glyph = 7'b0010010;
      4'h6:    glyph = 7'b0000010;
      4'h7:    glyph = 7'b1111000;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0010000;
      4'hA:    glyph = 7'b0001000;
      4'hB:    glyph = 7'b0000011;
      4'hC:    glyph = 7'b1000110;
      4'hD:    glyph = 7'b0100001;
      4'hE:    glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
    return glyph;
  endfunction

  // Next-state logic. The slot tick wins over the guard-end compare, so the
  // state machine always returns to GUARD when a new slot starts. The anode
  // register is computed from the next state, which makes the anode switch on
  // exactly GUARD_CYCLES edges after the selector changes. By then seg has
  // been showing the new digit for at least one cycle.
  always_comb begin
    tick         = (cnt_q == CNT_LAST);
    cnt_d        = tick ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    selector_d   = selector_q;
    frame_done_d = 1'b0;
    seg_d        = hex_to_seg(digit_in);
    an_d         = 4'b1111;
    digit_on     = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
    lz_d         = lz_q;
`endif

    if (tick) begin
      state_d      = ST_GUARD;
      selector_d   = (selector_q == 2'd0) ? 2'd2 : selector_q - 2'd1;
      frame_done_d = (selector_q == 2'd0);
    end else if (cnt_q == GUARD_LAST) begin
      state_d = ST_SHOW;
`ifdef LEADING_ZERO_BLANK_EN
      // Capture whether the most significant digit is zero at the moment
      // digit C starts showing; digit B uses it later in the same frame.
      if (selector_q == 2'd2) begin
        lz_d = (digit_in == 4'd0);
      end
`endif
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit C is judged on its own live value. Digit B is judged on its own
    // value together with the flag captured during C's slot.
    if (selector_q == 2'd2 && digit_in == 4'd0) begin
      digit_on = 1'b0;
    end else if (selector_q == 2'd1 && digit_in == 4'd0 && lz_q) begin
      digit_on = 1'b0;
    end
`endif

    if (state_d == ST_SHOW && !blank && digit_on) begin
      case (selector_q)
        2'd2:    an_d = 4'b1011;
        2'd1:    an_d = 4'b1101;
        default: an_d = 4'b1110;
      endcase
    end
  end

  // State and output registers, all returning to the idle display on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      state_q      <= ST_GUARD;
      selector_q   <= 2'd2;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      frame_done_q <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_q         <= 1'b0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      selector_q   <= selector_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
`ifdef LEADING_ZERO_BLANK_EN
      lz_q         <= lz_d;
`endif
    end
  end

  assign selector   = selector_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = 1'b1;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// tb_digit_scan_driver
//
// Directed bench for digit_scan_driver. Two instances share clock, reset and
// blank: a nominal one (REFRESH_DIV=8, GUARD_CYCLES=2) and a corner one
// (REFRESH_DIV=4, GUARD_CYCLES=3, one lit cycle per slot). Each has its own
// mux model of digits C/B/A. Expected values come from the cycle index k
// since the last reset edge. Digits C and B change only together with a
// reset, so the leading-zero flag is always consistent with them.
// If LEADING_ZERO_BLANK_EN is defined, the expected anodes include the
// leading-zero suppression.

module tb_digit_scan_driver;

  logic       clk;
  logic       reset;
  logic       blank;
  logic [1:0] sel_big, sel_sml;
  logic [3:0] din_big, din_sml;
  logic [3:0] an_big, an_sml;
  logic [6:0] seg_big, seg_sml;
  logic       dp_big, dp_sml;
  logic       fd_big, fd_sml;

  logic [3:0] val_a, val_b, val_c;
  int         k;
  int         n_checks;
  int         n_fail;

  digit_scan_driver #(.REFRESH_DIV(8), .GUARD_CYCLES(2)) u_dut_big (
    .clk(clk), .reset(reset), .selector(sel_big), .digit_in(din_big),
    .blank(blank), .an(an_big), .seg(seg_big), .dp(dp_big), .frame_done(fd_big)
  );

  digit_scan_driver #(.REFRESH_DIV(4), .GUARD_CYCLES(3)) u_dut_sml (
    .clk(clk), .reset(reset), .selector(sel_sml), .digit_in(din_sml),
    .blank(blank), .an(an_sml), .seg(seg_sml), .dp(dp_sml), .frame_done(fd_sml)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External digit muxes, one per instance.
  always_comb begin
    case (sel_big)
      2'd2:    din_big = val_c;
      2'd1:    din_big = val_b;
      default: din_big = val_a;
    endcase
    case (sel_sml)
      2'd2:    din_sml = val_c;
      2'd1:    din_sml = val_b;
      default: din_sml = val_a;
    endcase
  end

  function automatic logic [3:0] mux_digit(input logic [1:0] s);
    if (s == 2'd2) return val_c;
    if (s == 2'd1) return val_b;
    return val_a;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] g [16];
    g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return g[v];
  endfunction

  function automatic logic [1:0] exp_sel(input int kk, input int div);
    return 2'(2 - ((kk / div) % 3));
  endfunction

  function automatic logic [3:0] exp_an(input int kk, input int div, input int guard,
                                        input logic blank_prev);
    logic [3:0] r;
    int         s;
    r = 4'b1111;
    if (!blank_prev && (kk % div) >= guard) begin
      s = 2 - ((kk / div) % 3);
      r[s] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      if (s == 2 && val_c == 4'd0) r = 4'b1111;
      if (s == 1 && val_b == 4'd0 && val_c == 4'd0) r = 4'b1111;
`endif
    end
    return r;
  endfunction

  function automatic logic exp_fd(input int kk, input int div);
    return (kk > 0) && ((kk % (3 * div)) == 0);
  endfunction

  task automatic check_output(input string tag, input logic [6:0] observed,
                              input logic [6:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s at k=%0d: observed %b, expected %b", tag, k, observed, expected);
    end
  endtask

  // Drives reset/blank for one cycle, clocks, then checks both instances.
  task automatic apply_stimulus(input logic rst_in, input logic blank_in);
    logic [3:0] dig_big_before;
    logic [3:0] dig_sml_before;
    reset = rst_in;
    blank = blank_in;
    dig_big_before = mux_digit(exp_sel(k, 8));
    dig_sml_before = mux_digit(exp_sel(k, 4));
    @(posedge clk);
    #1;
    if (rst_in) k = 0;
    else k++;
    check_output("sel_big", 7'(sel_big), 7'(exp_sel(k, 8)));
    check_output("an_big",  7'(an_big),  7'(exp_an(k, 8, 2, blank_in)));
    check_output("seg_big", seg_big, rst_in ? 7'h7F : hex_seg(dig_big_before));
    check_output("fd_big",  7'(fd_big),  7'(exp_fd(k, 8)));
    check_output("sel_sml", 7'(sel_sml), 7'(exp_sel(k, 4)));
    check_output("an_sml",  7'(an_sml),  7'(exp_an(k, 4, 3, blank_in)));
    check_output("seg_sml", seg_sml, rst_in ? 7'h7F : hex_seg(dig_sml_before));
    check_output("fd_sml",  7'(fd_sml),  7'(exp_fd(k, 4)));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    k        = 0;
    reset    = 1'b1;
    blank    = 1'b0;
    val_c    = 4'd8;
    val_b    = 4'd0;
    val_a    = 4'd5;

    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("dp_big", 7'(dp_big), 7'd1);
    check_output("dp_sml", 7'(dp_sml), 7'd1);

    $display("[TB] two frames with C=8 B=0 A=5");
    repeat (58) apply_stimulus(1'b0, 1'b0);

    $display("[TB] digit A changes while showing");
    val_a = 4'd9;
    repeat (3) apply_stimulus(1'b0, 1'b0);

    $display("[TB] blank held for 20 cycles");
    repeat (20) apply_stimulus(1'b0, 1'b1);
    repeat (12) apply_stimulus(1'b0, 1'b0);

    $display("[TB] reset pulse during digit B show");
    for (int i = 0; i < 30 && !(((k / 8) % 3) == 1 && (k % 8) >= 3); i++) begin
      apply_stimulus(1'b0, 1'b0);
    end
    check_output("in_b_show", 7'(an_big), 7'b1101);
    apply_stimulus(1'b1, 1'b0);
    repeat (30) apply_stimulus(1'b0, 1'b0);

    $display("[TB] digits C=0 B=0 A=7");
    val_c = 4'd0;
    val_b = 4'd0;
    val_a = 4'd7;
    apply_stimulus(1'b1, 1'b0);
    repeat (48) apply_stimulus(1'b0, 1'b0);

    $display("[TB] digits C=0 B=3 A=7");
    val_b = 4'd3;
    apply_stimulus(1'b1, 1'b0);
    repeat (48) apply_stimulus(1'b0, 1'b0);

    check_output("dp_end", 7'(dp_big), 7'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
